// File: rtl/digit_frame_streamer_if.sv
// OLED driver link: pixel byte, write request, end-of-frame request, driver ready.
// Latency: none; this interface only carries wires.
// Backpressure: the driver acknowledges a request by dropping oled_ready_in.
// Ports (master = streamer):
//   oled_data_out      8  pixel byte
//   oled_write_stb_out 1  byte valid / write request
//   oled_sync_stb_out  1  end-of-frame request
//   oled_ready_in      1  driver ready; a low level acknowledges the request
interface digit_frame_streamer_if;
    logic [7:0] oled_data_out;
    logic       oled_write_stb_out;
    logic       oled_sync_stb_out;
    logic       oled_ready_in;

    modport master (
        output oled_data_out,
        output oled_write_stb_out,
        output oled_sync_stb_out,
        input  oled_ready_in
    );

    modport slave (
        input  oled_data_out,
        input  oled_write_stb_out,
        input  oled_sync_stb_out,
        output oled_ready_in
    );
endinterface

// File: rtl/digit_frame_streamer.sv
// Seven-segment frame generator: one full screen of pixel bytes, then one sync strobe.
// Latency: the first write strobe appears one cycle after the refresh edge; each byte costs at least 2 cycles.
// Backpressure: each byte or sync is held until the driver drops oled_ready_in; refreshes while busy queue one deep, latest wins.
// Ports: clk_in, reset_n_in (sync, active low), digits_in (MS nibble = leftmost digit),
//        dp_in (bit i = nibble i), refresh_stb_in, ready_out (high in IDLE), oled (master side of the driver link).
// Optional feature: LEADING_ZERO_BLANK_EN blanks leading zero digits.
module digit_frame_streamer #(
    parameter int DIGITS_NUM       = 6,
    parameter int DIGIT_X_SIZE_PX  = 21,
    parameter int LCD_X_SIZE_PX    = 128,
    parameter int LCD_Y_SIZE_BYTES = 4
) (
    input  logic                    clk_in,
    input  logic                    reset_n_in,
    input  logic [4*DIGITS_NUM-1:0] digits_in,
    input  logic [DIGITS_NUM-1:0]   dp_in,
    input  logic                    refresh_stb_in,
    output logic                    ready_out,
    digit_frame_streamer_if.master  oled
);
    localparam int PAD_COLS = LCD_X_SIZE_PX - DIGITS_NUM * DIGIT_X_SIZE_PX;
    localparam int COL_W    = $clog2(LCD_X_SIZE_PX + 1);
    localparam int PAGE_W   = $clog2(LCD_Y_SIZE_BYTES + 1);
    localparam int DCOL_W   = $clog2(DIGIT_X_SIZE_PX + 1);
    localparam int DIG_W    = $clog2(DIGITS_NUM + 1);

    localparam logic [COL_W-1:0]  PAD_C     = COL_W'(PAD_COLS);
    localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(LCD_X_SIZE_PX - 1);
    localparam logic [PAGE_W-1:0] LAST_PAGE = PAGE_W'(LCD_Y_SIZE_BYTES - 1);
    localparam logic [DCOL_W-1:0] LAST_DCOL = DCOL_W'(DIGIT_X_SIZE_PX - 1);

    // Column masks of the 21x32 glyph: bit n = pixel row n.
    localparam logic [31:0] ROWS_TOP   = 32'h0000_0006;  // segment a
    localparam logic [31:0] ROWS_UPPER = 32'h0000_7FF8;  // segments b, f
    localparam logic [31:0] ROWS_MID   = 32'h0001_8000;  // segment g
    localparam logic [31:0] ROWS_LOWER = 32'h1FFE_0000;  // segments c, e
    localparam logic [31:0] ROWS_BOT   = 32'h6000_0000;  // segment d

    if (PAD_COLS < 0) begin : g_fit_check
        $error("digit_frame_streamer: digits are wider than the display");
    end
    if (DIGIT_X_SIZE_PX != 21) begin : g_cell_check
        $error("digit_frame_streamer: glyph renderer is 21 columns wide");
    end
    if (DIGITS_NUM < 1 || DIGITS_NUM > 6) begin : g_num_check
        $error("digit_frame_streamer: DIGITS_NUM must be 1..6");
    end

    typedef enum logic [2:0] {
        S_RESET, S_IDLE, S_SEND_DATA, S_WAIT_DATA, S_SEND_SYNC, S_WAIT_SYNC
    } state_t;

    state_t                  state_q;
    logic [4*DIGITS_NUM-1:0] digits_q, shadow_dg_q, src_dg;
    logic [DIGITS_NUM-1:0]   dp_q, shadow_dp_q, src_dp;
    logic                    pending_q;
    logic [COL_W-1:0]        col_q, col_d;
    logic [PAGE_W-1:0]       page_q, page_d;
    logic [DCOL_W-1:0]       dcol_q, dcol_d;
    logic [DIG_W-1:0]        dig_q, dig_d;
    logic [7:0]              data_q, nxt_byte, start_byte;
    logic                    wr_q, sync_q, ready_q;
    logic                    last_byte;

    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'h0: seg7 = 7'h3F;  4'h1: seg7 = 7'h06;  4'h2: seg7 = 7'h5B;  4'h3: seg7 = 7'h4F;
            4'h4: seg7 = 7'h66;  4'h5: seg7 = 7'h6D;  4'h6: seg7 = 7'h7D;  4'h7: seg7 = 7'h07;
            4'h8: seg7 = 7'h7F;  4'h9: seg7 = 7'h6F;  4'hA: seg7 = 7'h77;  4'hB: seg7 = 7'h7C;
            4'hC: seg7 = 7'h39;  4'hD: seg7 = 7'h5E;  4'hE: seg7 = 7'h79;  default: seg7 = 7'h71;
        endcase
    endfunction

    // One byte of a digit cell: build the 32-row column mask, then pick the page.
    function automatic logic [7:0] cell_byte(input logic [DCOL_W-1:0] x, input logic [PAGE_W-1:0] page,
                                             input logic [6:0] seg, input logic dp);
        int          xi, pi;
        logic [31:0] col_bits, sh;
        logic [7:0]  b;
        xi = int'(x);
        pi = int'(page);
        col_bits = 32'h0;
        if (xi >= 4 && xi <= 14)
            col_bits = ({32{seg[0]}} & ROWS_TOP) | ({32{seg[6]}} & ROWS_MID) | ({32{seg[3]}} & ROWS_BOT);
        else if (xi >= 15 && xi <= 16)
            col_bits = ({32{seg[1]}} & ROWS_UPPER) | ({32{seg[2]}} & ROWS_LOWER);
        else if (xi >= 2 && xi <= 3)
            col_bits = ({32{seg[5]}} & ROWS_UPPER) | ({32{seg[4]}} & ROWS_LOWER);
        sh = col_bits >> (8 * pi);
        b  = (pi < 4) ? sh[7:0] : 8'h00;
        if (dp && page == LAST_PAGE && xi >= DIGIT_X_SIZE_PX - 2)
            b = b | 8'hC0;
        return b;
    endfunction

`ifdef LEADING_ZERO_BLANK_EN
    // Scan from the MSD; stop at the first non-zero digit or the first set point.
    function automatic logic [DIGITS_NUM-1:0] blank_mask(input logic [4*DIGITS_NUM-1:0] dg,
                                                         input logic [DIGITS_NUM-1:0] dpv);
        logic [DIGITS_NUM-1:0] m;
        logic                  stop;
        m    = '0;
        stop = 1'b0;
        for (int i = DIGITS_NUM - 1; i >= 1; i--) begin
            if (!stop && dg[i*4 +: 4] == 4'h0 && !dpv[i]) m[i] = 1'b1;
            else                                          stop = 1'b1;
        end
        return m;
    endfunction
`endif

    function automatic logic [7:0] frame_byte(input logic pad, input logic [DIG_W-1:0] dig,
                                              input logic [DCOL_W-1:0] dcol, input logic [PAGE_W-1:0] page,
                                              input logic [4*DIGITS_NUM-1:0] dg,
                                              input logic [DIGITS_NUM-1:0] dpv);
        int                    idx;
        logic [DIGITS_NUM-1:0] blank;
        logic [6:0]            seg;
        idx = DIGITS_NUM - 1 - int'(dig);
`ifdef LEADING_ZERO_BLANK_EN
        blank = blank_mask(dg, dpv);
`else
        blank = '0;
`endif
        seg = blank[idx] ? 7'h00 : seg7(dg[idx*4 +: 4]);
        return pad ? 8'h00 : cell_byte(dcol, page, seg, dpv[idx]);
    endfunction

    // Next scan position: page is the fast counter; digit counters only move on digit columns.
    always_comb begin
        page_d = page_q + 1'b1;
        col_d  = col_q;
        dcol_d = dcol_q;
        dig_d  = dig_q;
        if (page_q == LAST_PAGE) begin
            page_d = '0;
            col_d  = col_q + 1'b1;
            if (col_q >= PAD_C) begin
                if (dcol_q == LAST_DCOL) begin
                    dcol_d = '0;
                    dig_d  = dig_q + 1'b1;
                end else begin
                    dcol_d = dcol_q + 1'b1;
                end
            end
        end
    end

    assign last_byte  = (page_q == LAST_PAGE) && (col_q == LAST_COL);
    assign src_dg     = refresh_stb_in ? digits_in : shadow_dg_q;
    assign src_dp     = refresh_stb_in ? dp_in     : shadow_dp_q;
    assign nxt_byte   = frame_byte(col_d < PAD_C, dig_d, dcol_d, page_d, digits_q, dp_q);
    assign start_byte = frame_byte(PAD_COLS > 0, '0, '0, '0, src_dg, src_dp);

    always_ff @(posedge clk_in) begin
        if (!reset_n_in) begin
            state_q     <= S_RESET;
            digits_q    <= '0;
            dp_q        <= '0;
            shadow_dg_q <= '0;
            shadow_dp_q <= '0;
            pending_q   <= 1'b0;
            col_q       <= '0;
            page_q      <= '0;
            dcol_q      <= '0;
            dig_q       <= '0;
            data_q      <= 8'h00;
            wr_q        <= 1'b0;
            sync_q      <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            if (refresh_stb_in && state_q != S_IDLE) begin
                shadow_dg_q <= digits_in;
                shadow_dp_q <= dp_in;
                pending_q   <= 1'b1;
            end
            case (state_q)
                S_RESET: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                end
                S_IDLE: begin
                    if (refresh_stb_in || pending_q) begin
                        digits_q  <= src_dg;
                        dp_q      <= src_dp;
                        pending_q <= 1'b0;
                        col_q     <= '0;
                        page_q    <= '0;
                        dcol_q    <= '0;
                        dig_q     <= '0;
                        data_q    <= start_byte;
                        wr_q      <= 1'b1;
                        ready_q   <= 1'b0;
                        state_q   <= S_SEND_DATA;
                    end
                end
                S_SEND_DATA: begin
                    if (!oled.oled_ready_in) begin
                        wr_q    <= 1'b0;
                        state_q <= S_WAIT_DATA;
                    end
                end
                S_WAIT_DATA: begin
                    if (oled.oled_ready_in) begin
                        if (last_byte) begin
                            data_q  <= 8'h00;
                            sync_q  <= 1'b1;
                            state_q <= S_SEND_SYNC;
                        end else begin
                            col_q   <= col_d;
                            page_q  <= page_d;
                            dcol_q  <= dcol_d;
                            dig_q   <= dig_d;
                            data_q  <= nxt_byte;
                            wr_q    <= 1'b1;
                            state_q <= S_SEND_DATA;
                        end
                    end
                end
                S_SEND_SYNC: begin
                    if (!oled.oled_ready_in) begin
                        sync_q  <= 1'b0;
                        state_q <= S_WAIT_SYNC;
                    end
                end
                S_WAIT_SYNC: begin
                    if (oled.oled_ready_in) begin
                        ready_q <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_RESET;
            endcase
        end
    end

    assign ready_out               = ready_q;
    assign oled.oled_data_out      = data_q;
    assign oled.oled_write_stb_out = wr_q;
    assign oled.oled_sync_stb_out  = sync_q;
endmodule

// File: tb/tb_digit_frame_streamer.sv
// Bench for digit_frame_streamer: randomized frames against a pixel-level glyph model.
// Latency: a modelled OLED driver acks each request after a chosen number of held cycles.
// Backpressure: driver stall length is set per test through dly_min/dly_max.
module tb_digit_frame_streamer;
    localparam int N   = 6;
    localparam int XS  = 21;
    localparam int LX  = 128;
    localparam int LY  = 4;
    localparam int PAD = LX - N * XS;
    localparam int FRAME_BYTES = LX * LY;

    logic        clk_in = 1'b0;
    logic        reset_n;
    logic [23:0] digits;
    logic [5:0]  dp;
    logic        refresh;
    logic        ready_out;

    digit_frame_streamer_if oled_if ();

    digit_frame_streamer #(
        .DIGITS_NUM(N), .DIGIT_X_SIZE_PX(XS), .LCD_X_SIZE_PX(LX), .LCD_Y_SIZE_BYTES(LY)
    ) dut (
        .clk_in(clk_in),
        .reset_n_in(reset_n),
        .digits_in(digits),
        .dp_in(dp),
        .refresh_stb_in(refresh),
        .ready_out(ready_out),
        .oled(oled_if)
    );

    always #5 clk_in = ~clk_in;

    int n_checks   = 0;
    int n_failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model: geometry of lit pixels ----------------
    function automatic logic [6:0] seg_ref(input logic [3:0] v);
        logic [6:0] t [16];
        t = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        return t[v];
    endfunction

    // Segment rectangles in a 21x32 cell, bit order {g,f,e,d,c,b,a}.
    function automatic bit seg_px(input logic [6:0] s, input int x, input int y);
        bit on;
        on = 0;
        if (s[0] && x >= 4  && x <= 14 && y >= 1  && y <= 2)  on = 1;
        if (s[1] && x >= 15 && x <= 16 && y >= 3  && y <= 14) on = 1;
        if (s[2] && x >= 15 && x <= 16 && y >= 17 && y <= 28) on = 1;
        if (s[3] && x >= 4  && x <= 14 && y >= 29 && y <= 30) on = 1;
        if (s[4] && x >= 2  && x <= 3  && y >= 17 && y <= 28) on = 1;
        if (s[5] && x >= 2  && x <= 3  && y >= 3  && y <= 14) on = 1;
        if (s[6] && x >= 4  && x <= 14 && y >= 15 && y <= 16) on = 1;
        return on;
    endfunction

    // Index of the leftmost digit that is drawn; digits left of it are blank.
    function automatic int first_shown(input logic [23:0] dg, input logic [5:0] dpv);
        int f;
`ifdef LEADING_ZERO_BLANK_EN
        f = 0;
        for (int i = 1; i < N; i++)
            if (dg[i*4 +: 4] != 4'h0 || dpv[i]) f = i;
`else
        f = N - 1;
`endif
        return f;
    endfunction

    function automatic logic [7:0] ref_byte(input logic [23:0] dg, input logic [5:0] dpv, input int idx);
        int         col, page, x, nib, y;
        logic [6:0] s;
        logic [7:0] r;
        col  = idx / LY;
        page = idx % LY;
        r    = 8'h00;
        if (col >= PAD) begin
            x   = (col - PAD) % XS;
            nib = N - 1 - (col - PAD) / XS;
            s   = (nib > first_shown(dg, dpv)) ? 7'h00 : seg_ref(dg[nib*4 +: 4]);
            for (int b = 0; b < 8; b++) begin
                y = page * 8 + b;
                if (seg_px(s, x, y) || (dpv[nib] && page == LY - 1 && x >= XS - 2 && b >= 6))
                    r[b] = 1'b1;
            end
        end
        return r;
    endfunction

    // ---------------- OLED driver model ----------------
    logic [7:0] frame_q[$];
    logic [7:0] last_frame[$];
    int         hist_q[$];
    int         last_hist[$];
    int         sync_cnt     = 0;
    int         ready_hi_cnt = 0;
    int         unstable_cnt = 0;
    int         dly_min      = 0;
    int         dly_max      = 0;

    initial begin : driver
        int         stb_cycles;
        int         cur_delay;
        logic [7:0] held_byte;
        stb_cycles = 0;
        cur_delay  = 0;
        held_byte  = 8'h00;
        oled_if.oled_ready_in = 1'b1;
        forever begin
            @(negedge clk_in);
            if (!reset_n) begin
                oled_if.oled_ready_in = 1'b1;
                stb_cycles = 0;
                frame_q.delete();
                hist_q.delete();
            end else if (!oled_if.oled_ready_in) begin
                oled_if.oled_ready_in = 1'b1;
            end else if (oled_if.oled_write_stb_out) begin
                if (stb_cycles == 0) begin
                    held_byte = oled_if.oled_data_out;
                    cur_delay = int'($urandom_range(dly_max, dly_min));
                end else if (oled_if.oled_data_out != held_byte) begin
                    unstable_cnt++;
                end
                stb_cycles++;
                if (stb_cycles > cur_delay) begin
                    frame_q.push_back(oled_if.oled_data_out);
                    hist_q.push_back(stb_cycles);
                    stb_cycles = 0;
                    oled_if.oled_ready_in = 1'b0;
                end
            end else if (oled_if.oled_sync_stb_out) begin
                last_frame = frame_q;
                last_hist  = hist_q;
                frame_q.delete();
                hist_q.delete();
                sync_cnt++;
                oled_if.oled_ready_in = 1'b0;
            end
            if (ready_out) ready_hi_cnt++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic strobe(input logic [23:0] d, input logic [5:0] p);
        @(negedge clk_in);
        digits  = d;
        dp      = p;
        refresh = 1'b1;
        @(negedge clk_in);
        refresh = 1'b0;
    endtask

    task automatic wait_syncs(input int target, input int budget);
        int n = 0;
        while (sync_cnt < target && n < budget) begin
            @(negedge clk_in);
            n++;
        end
        if (sync_cnt < target) check("sync_timeout", sync_cnt, target);
    endtask

    task automatic wait_ready(input int budget);
        int n = 0;
        while (!ready_out && n < budget) begin
            @(negedge clk_in);
            n++;
        end
        check("ready_back", ready_out, 1'b1);
    endtask

    task automatic wait_bytes(input int cnt, input int budget);
        int n = 0;
        while (frame_q.size() < cnt && n < budget) begin
            @(negedge clk_in);
            n++;
        end
        if (frame_q.size() < cnt) check("byte_timeout", frame_q.size(), cnt);
    endtask

    task automatic check_frame(input logic [23:0] d, input logic [5:0] p);
        check("frame_len", last_frame.size(), FRAME_BYTES);
        for (int i = 0; i < FRAME_BYTES && i < last_frame.size(); i++)
            check($sformatf("byte%0d d=%06h dp=%02h", i, d, p), last_frame[i], ref_byte(d, p, i));
        check("data_stable", unstable_cnt, 0);
    endtask

    task automatic run_frame(input logic [23:0] d, input logic [5:0] p);
        int base;
        wait_ready(5000);
        base = sync_cnt;
        strobe(d, p);
        wait_syncs(base + 1, 10000);
        check_frame(d, p);
        wait_ready(100);
        check("one_sync", sync_cnt, base + 1);
    endtask

    // ---------------- test sequence ----------------
    initial begin : main
        logic [23:0] a0, a, b;
        logic [5:0]  p0, pa, pb;
        int          base, r0;
        reset_n = 1'b0;
        refresh = 1'b0;
        digits  = 24'h0;
        dp      = 6'h0;

        repeat (3) @(posedge clk_in);
        #1;
        check("rst_ready", ready_out, 1'b0);
        check("rst_wr",    oled_if.oled_write_stb_out, 1'b0);
        check("rst_sync",  oled_if.oled_sync_stb_out, 1'b0);
        check("rst_data",  oled_if.oled_data_out, 8'h00);
        @(negedge clk_in);
        reset_n = 1'b1;
        @(posedge clk_in);
        #1;
        check("ready_after_reset", ready_out, 1'b1);

        // Directed frames with an immediate-ack driver.
        run_frame(24'h123456, 6'b000000);
        run_frame(24'h123456, 6'b000100);
        run_frame(24'h000042, 6'b000000);
        run_frame(24'h000005, 6'b001000);
        run_frame(24'h000000, 6'b000000);

        // Driver stalls 5 cycles on every byte.
        dly_min = 5;
        dly_max = 5;
        run_frame(24'($urandom), 6'($urandom));
        check("stb_hold_first", last_hist.size() > 0 ? last_hist[0] : 0, 6);
        check("stb_hold_last",  last_hist.size() == FRAME_BYTES ? last_hist[FRAME_BYTES-1] : 0, 6);

        // Random frames with random stalls.
        dly_min = 0;
        dly_max = 2;
        for (int k = 0; k < 3; k++)
            run_frame(24'($urandom), 6'($urandom));

        // Two strobes during a frame: only the latest is drawn, once.
        dly_max = 1;
        a0 = 24'($urandom); p0 = 6'($urandom);
        a  = 24'($urandom); pa = 6'($urandom);
        b  = 24'($urandom); pb = 6'($urandom);
        wait_ready(5000);
        base = sync_cnt;
        strobe(a0, p0);
        wait_bytes(40, 2000);
        strobe(a, pa);
        repeat (7) @(negedge clk_in);
        strobe(b, pb);
        r0 = ready_hi_cnt;
        wait_syncs(base + 1, 10000);
        check_frame(a0, p0);
        wait_syncs(base + 2, 10000);
        check("ready_pulse", ready_hi_cnt - r0, 1);
        check_frame(b, pb);
        repeat (1500) @(negedge clk_in);
        check("no_extra_frame", sync_cnt, base + 2);
        check("ready_idle", ready_out, 1'b1);

        // Reset mid-frame with a refresh queued: abort, no sync, queue cleared.
        dly_max = 0;
        wait_ready(5000);
        base = sync_cnt;
        strobe(24'($urandom), 6'($urandom));
        wait_bytes(100, 2000);
        strobe(24'($urandom), 6'($urandom));
        wait_bytes(300, 2000);
        reset_n = 1'b0;
        @(posedge clk_in);
        #1;
        check("abort_wr",    oled_if.oled_write_stb_out, 1'b0);
        check("abort_sync",  oled_if.oled_sync_stb_out, 1'b0);
        check("abort_data",  oled_if.oled_data_out, 8'h00);
        check("abort_ready", ready_out, 1'b0);
        repeat (3) @(negedge clk_in);
        reset_n = 1'b1;
        repeat (300) @(negedge clk_in);
        check("pending_cleared", frame_q.size(), 0);
        check("no_sync_on_abort", sync_cnt, base);
        run_frame(24'h987654, 6'b100001);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
        $finish;
    end
endmodule
